store_trace_buffer: RTL

STORE_TRACE_BUFFER -- requirements
Module: store_trace_buffer

---
 rtl/store_trace_buffer.sv | 86 ++++++++
 1 files changed

// File: rtl/store_trace_buffer.sv
// store_trace_buffer: captures processor stores into a small FIFO, then drains them on a dump request
module store_trace_buffer #(
    parameter int N     = 64,
    parameter int DEPTH = 8,
    parameter int SEQW  = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     DM_writeEnable,
    input  logic [N-1:0]             DM_addr,
    input  logic [N-1:0]             DM_writeData,
    input  logic                     dump,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_addr,
    output logic [N-1:0]             out_data,
    output logic [SEQW-1:0]          out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   head, tail;
    logic [SEQW-1:0] seq;
    logic            dump_q;
    logic            store, push, pop, dump_edge;
    logic [CW-1:0]   count_post;
    logic [N-1:0]    addr_mem [DEPTH];
    logic [N-1:0]    data_mem [DEPTH];
    logic [SEQW-1:0] seq_mem  [DEPTH];

    assign out_valid = (state == DRAIN) && (count != '0);
    assign out_addr  = out_valid ? addr_mem[head] : '0;
    assign out_data  = out_valid ? data_mem[head] : '0;
    assign out_seq   = out_valid ? seq_mem[head]  : '0;
    assign done      = (state == DONE);

    // Store/pop qualification and next-state; a store in the dump-edge cycle counts toward the drain decision
    always_comb begin
        store      = (state == CAPTURE) && DM_writeEnable;
        push       = store && (count != CW'(DEPTH));
        pop        = out_valid && out_ready;
        dump_edge  = dump && !dump_q;
        count_post = count + CW'(push);
        state_next = state;
        if (state == CAPTURE && dump_edge)
            state_next = (count_post != '0) ? DRAIN : DONE;
        else if (state == DRAIN && pop && count == CW'(1))
            state_next = DONE;
    end

    // Control state: FSM, pointers, occupancy, sequence counter and sticky overflow
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state    <= CAPTURE;
            dump_q   <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            seq      <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            dump_q   <= dump;
            head     <= head + AW'(pop);
            tail     <= tail + AW'(push);
            count    <= count + CW'(push) - CW'(pop);
            seq      <= seq + SEQW'(store);
            overflow <= overflow | (store && !push);
        end
    end

    // Entry storage is left uncleared; the output mask hides stale contents
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            addr_mem[tail] <= DM_addr;
            data_mem[tail] <= DM_writeData;
            seq_mem[tail]  <= seq;
        end
    end
endmodule
